// File: rtl/icache_responder_if.sv
// icache_responder_if: fetch-side and refill-side signals of the instruction cache.
// The cache itself is the slave; the fetch stage plus memory port form the master.
interface icache_responder_if;
   logic [31:0] fetch_addr;
   logic        fetch_flush;
   logic [31:0] fetch_data;
   logic        fetch_valid;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;

   modport slave (
      input  fetch_addr, fetch_flush, mem_req_ready, mem_resp_valid, mem_resp_data,
      output fetch_data, fetch_valid, mem_req_valid, mem_req_addr
   );

   modport master (
      output fetch_addr, fetch_flush, mem_req_ready, mem_resp_valid, mem_resp_data,
      input  fetch_data, fetch_valid, mem_req_valid, mem_req_addr
   );
endinterface

// File: rtl/icache_responder.sv
// icache_responder: direct-mapped instruction cache, responder side of fetch.
// One-cycle lookup latency; misses refill a whole line from a word-serial port.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
module icache_responder #(
   parameter int LINES             = 64,
   parameter int WORDS_PER_LINE    = 4,
   parameter int RESET_VECTOR_WARM = 0
) (
   input  logic                clk,
   input  logic                reset,
   icache_responder_if.slave   bus
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]         stat_hits,
   output logic [31:0]         stat_misses
`endif
);

   localparam int OFF_W = $clog2(WORDS_PER_LINE);
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = 30 - OFF_W - IDX_W;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL} state_t;

   state_t             state_q;
   logic [LINES-1:0]   valid_q;
   logic [OFF_W-1:0]   cnt_q;
   logic               fetch_valid_q;
   logic [31:0]        fetch_data_q;
   logic               req_valid_q;
   logic [31:0]        req_addr_q;
`ifdef ICACHE_STATS_EN
   logic [31:0]        hits_q;
   logic [31:0]        misses_q;
`endif

   // Tag and data storage; contents deliberately have no reset.
   logic [TAG_W-1:0]   tag_q  [LINES];
   logic [31:0]        data_q [LINES*WORDS_PER_LINE];

   logic [OFF_W-1:0]   look_off_s;
   logic [IDX_W-1:0]   look_idx_s;
   logic [TAG_W-1:0]   look_tag_s;
   logic               look_hit_s;
   logic [31:0]        look_data_s;
   logic [31:0]        look_line_s;
   logic [IDX_W-1:0]   fill_idx_s;
   logic [TAG_W-1:0]   fill_tag_s;
   logic               beat_we_s;
   logic               last_beat_s;
   logic               unused_s;

   assign look_off_s  = bus.fetch_addr[OFF_W+1:2];
   assign look_idx_s  = bus.fetch_addr[OFF_W+IDX_W+1:OFF_W+2];
   assign look_tag_s  = bus.fetch_addr[31:OFF_W+IDX_W+2];
   assign look_hit_s  = valid_q[look_idx_s] && (tag_q[look_idx_s] == look_tag_s);
   assign look_data_s = data_q[{look_idx_s, look_off_s}];
   assign look_line_s = {bus.fetch_addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
   assign fill_idx_s  = req_addr_q[OFF_W+IDX_W+1:OFF_W+2];
   assign fill_tag_s  = req_addr_q[31:OFF_W+IDX_W+2];
   assign beat_we_s   = (state_q == S_FILL) && bus.mem_resp_valid && !reset;
   assign last_beat_s = (cnt_q == OFF_W'(WORDS_PER_LINE - 1));
   assign unused_s    = &{1'b0, bus.fetch_addr[1:0], (RESET_VECTOR_WARM != 0)};

   assign bus.fetch_valid   = fetch_valid_q;
   assign bus.fetch_data    = fetch_data_q;
   assign bus.mem_req_valid = req_valid_q;
   assign bus.mem_req_addr  = req_addr_q;
`ifdef ICACHE_STATS_EN
   assign stat_hits   = hits_q;
   assign stat_misses = misses_q;
`endif

   // Refill beats land in the data array; the tag is written with the last beat.
   always_ff @(posedge clk) begin
      if (beat_we_s) begin
         data_q[{fill_idx_s, cnt_q}] <= bus.mem_resp_data;
         if (last_beat_s) begin
            tag_q[fill_idx_s] <= fill_tag_s;
         end
      end
   end

   // Lookup / request / fill sequencing with all responses registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         valid_q       <= '0;
         cnt_q         <= '0;
         fetch_valid_q <= 1'b0;
         fetch_data_q  <= 32'd0;
         req_valid_q   <= 1'b0;
         req_addr_q    <= 32'd0;
`ifdef ICACHE_STATS_EN
         hits_q        <= 32'd0;
         misses_q      <= 32'd0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (look_hit_s) begin
                  // A flush in the lookup cycle kills this response only.
                  fetch_valid_q <= !bus.fetch_flush;
                  fetch_data_q  <= look_data_s;
               end else begin
                  // Invalidate now so a partially refilled line never hits.
                  fetch_valid_q        <= 1'b0;
                  req_addr_q           <= look_line_s;
                  req_valid_q          <= 1'b1;
                  valid_q[look_idx_s]  <= 1'b0;
                  state_q              <= S_REQ;
               end
`ifdef ICACHE_STATS_EN
               if (!bus.fetch_flush) begin
                  if (look_hit_s) begin
                     if (hits_q != 32'hFFFF_FFFF) hits_q <= hits_q + 32'd1;
                  end else begin
                     if (misses_q != 32'hFFFF_FFFF) misses_q <= misses_q + 32'd1;
                  end
               end
`endif
            end
            S_REQ: begin
               fetch_valid_q <= 1'b0;
               if (req_valid_q && bus.mem_req_ready) begin
                  req_valid_q <= 1'b0;
                  cnt_q       <= '0;
                  state_q     <= S_FILL;
               end
            end
            S_FILL: begin
               fetch_valid_q <= 1'b0;
               if (bus.mem_resp_valid) begin
                  cnt_q <= cnt_q + OFF_W'(1);
                  if (last_beat_s) begin
                     valid_q[fill_idx_s] <= 1'b1;
                     state_q             <= S_IDLE;
                  end
               end
            end
            default: begin
               state_q       <= S_IDLE;
               fetch_valid_q <= 1'b0;
               req_valid_q   <= 1'b0;
               cnt_q         <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder: directed plan scenarios followed by random traffic,
// compared each cycle against a line-level cache model with a known memory image.
module tb_icache_responder;
   logic clk = 1'b0;
   logic reset;
   icache_responder_if bus ();
`ifdef ICACHE_STATS_EN
   logic [31:0] stat_hits;
   logic [31:0] stat_misses;
`endif

   icache_responder #(.LINES(64), .WORDS_PER_LINE(4), .RESET_VECTOR_WARM(0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef ICACHE_STATS_EN
      ,
      .stat_hits   (stat_hits),
      .stat_misses (stat_misses)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   localparam int M_LOOK = 0;
   localparam int M_REQ  = 1;
   localparam int M_FILL = 2;

   // reference model state
   int          mode = M_LOOK;
   bit          mvalid [64];
   logic [21:0] mtag   [64];
   logic [31:0] mline;
   int          mbeats;
   logic        have_exp = 1'b0;
   logic        exp_valid, exp_req, exp_zero;
   logic [31:0] exp_data, exp_req_addr;
   logic [31:0] exp_hits, exp_misses;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Backing memory image (word-aligned addresses).
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: mem_word = 32'h0000_0011;
         32'h0000_0004: mem_word = 32'h0000_0022;
         32'h0000_0008: mem_word = 32'h0000_0033;
         32'h0000_000C: mem_word = 32'h0000_0044;
         32'h0000_0400: mem_word = 32'h0000_00A0;
         32'h0000_0404: mem_word = 32'h0000_00A1;
         32'h0000_0408: mem_word = 32'h0000_00A2;
         32'h0000_040C: mem_word = 32'h0000_00A3;
         default:       mem_word = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
      endcase
   endfunction

   // One clock: check last cycle's outcome, drive inputs, predict the next outcome.
   task automatic cycle(input logic [31:0] a, input logic fl, input logic rdy,
                        input logic rv, input logic rst);
      logic [31:0] beat;
      int          idx;
      logic [21:0] tg;
      if (have_exp) begin
         check_val("fetch_valid", {31'd0, bus.fetch_valid}, {31'd0, exp_valid});
         if (exp_valid || exp_zero) check_val("fetch_data", bus.fetch_data, exp_data);
         check_val("mem_req_valid", {31'd0, bus.mem_req_valid}, {31'd0, exp_req});
         if (exp_req || exp_zero) check_val("mem_req_addr", bus.mem_req_addr, exp_req_addr);
`ifdef ICACHE_STATS_EN
         check_val("stat_hits", stat_hits, exp_hits);
         check_val("stat_misses", stat_misses, exp_misses);
`endif
      end
      beat = (mode == M_FILL) ? mem_word(mline + 32'(mbeats * 4)) : $urandom();
      reset              = rst;
      bus.fetch_addr     = a;
      bus.fetch_flush    = fl;
      bus.mem_req_ready  = rdy;
      bus.mem_resp_valid = rv;
      bus.mem_resp_data  = beat;
      have_exp = 1'b1;
      exp_zero = 1'b0;
      if (rst) begin
         mode = M_LOOK;
         for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
         exp_valid = 1'b0; exp_data = 32'd0; exp_req = 1'b0; exp_req_addr = 32'd0;
         exp_zero = 1'b1; exp_hits = 32'd0; exp_misses = 32'd0;
      end else begin
         case (mode)
            M_LOOK: begin
               idx = int'(a[9:4]);
               tg  = a[31:10];
               if (mvalid[idx] && mtag[idx] == tg) begin
                  exp_valid = !fl;
                  exp_data  = mem_word({a[31:2], 2'b00});
                  if (!fl) exp_hits = exp_hits + 32'd1;
               end else begin
                  exp_valid    = 1'b0;
                  mline        = {a[31:4], 4'h0};
                  mvalid[idx]  = 1'b0;
                  exp_req      = 1'b1;
                  exp_req_addr = mline;
                  mode         = M_REQ;
                  if (!fl) exp_misses = exp_misses + 32'd1;
               end
            end
            M_REQ: begin
               exp_valid = 1'b0;
               if (rdy) begin
                  exp_req = 1'b0;
                  mode    = M_FILL;
                  mbeats  = 0;
               end
            end
            default: begin
               exp_valid = 1'b0;
               if (rv) begin
                  mbeats++;
                  if (mbeats == 4) begin
                     mvalid[int'(mline[9:4])] = 1'b1;
                     mtag[int'(mline[9:4])]   = mline[31:10];
                     mode = M_LOOK;
                  end
               end
            end
         endcase
      end
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] addr;
      reset = 1'b1;
      bus.fetch_addr = 32'd0; bus.fetch_flush = 1'b0; bus.mem_req_ready = 1'b0;
      bus.mem_resp_valid = 1'b0; bus.mem_resp_data = 32'd0;
      @(negedge clk);
      repeat (3) cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

      // cold miss, then the re-lookup hit and streaming hits
      repeat (6) cycle(32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
      cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(32'h4, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(32'h8, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(32'hC, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(32'hC, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef ICACHE_STATS_EN
      check_val("plan_stat_misses", stat_misses, 32'd1);
      check_val("plan_stat_hits", stat_hits, 32'd4);
`endif

      // conflict eviction: 0x400 then 0x000 on the same index
      repeat (7) cycle(32'h400, 1'b0, 1'b1, 1'b1, 1'b0);
      repeat (7) cycle(32'h000, 1'b0, 1'b1, 1'b1, 1'b0);

      // flush during fill, address moves to 0x104
      repeat (4) cycle(32'h100, 1'b0, 1'b1, 1'b1, 1'b0);
      cycle(32'h104, 1'b1, 1'b1, 1'b1, 1'b0);
      cycle(32'h104, 1'b0, 1'b1, 1'b1, 1'b0);
      repeat (2) cycle(32'h104, 1'b0, 1'b0, 1'b0, 1'b0);

      // reset after two beats, then the same line is refetched
      repeat (4) cycle(32'h200, 1'b0, 1'b1, 1'b1, 1'b0);
      cycle(32'h200, 1'b0, 1'b1, 1'b1, 1'b1);
      repeat (8) cycle(32'h200, 1'b0, 1'b1, 1'b1, 1'b0);

      // random traffic over a small, conflicting address pool
      addr = 32'h0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 99) < 40) addr = {addr[31:2] + 30'd1, addr[1:0]};
         else addr = ($urandom_range(0, 2) << 10) | ($urandom_range(0, 3) << 4) |
                     ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
         cycle(addr, ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0,
               $urandom_range(0, 1) ? 1'b1 : 1'b0,
               ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
               ($urandom_range(0, 999) < 5) ? 1'b1 : 1'b0);
      end
      cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
